// File: rtl/ring_node_router.sv
// -----------------------------------------------------------------------------
// ring_node_router
//
// Purpose
//   One node of a bidirectional instruction ring. Flits arrive on three input
//   ports (0 = CW ring, 1 = LOCAL inject, 2 = CCW ring). Each port has its own
//   FIFO. Each cycle a round-robin arbiter picks one FIFO head, decides its
//   shortest-path direction and loads it into a single registered output
//   stage. The flit is tagged with that direction and with the port it came
//   from.
//
// Flit fields
//   dest = data[DATA_W-1 -: ID_W]
//   orig = data[DATA_W-1-ID_W -: ID_W]
//   The payload leaves the router unmodified.
//
// Handshake (input and output sides alike)
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. The source holds valid and data stable until that edge. The sink's
//   ready never depends combinationally on valid. in_ready is derived from
//   registered state only. The output stage keeps out_* stable while
//   out_valid && !out_ready.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high. Empties the FIFOs and the output
//               stage and clears the arbiter pointer.
//   in_valid    [2:0]  per-port flit valid
//   in_ready    [2:0]  per-port FIFO not full (low while in reset)
//   in_data     [3*DATA_W-1:0]  port i at [i*DATA_W +: DATA_W]
//   out_valid   output register holds a flit
//   out_ready   downstream accepts the flit
//   out_data    [DATA_W-1:0]  flit payload
//   out_dir     [1:0]  2'b00 = CW, 2'b01 = LOCAL (eject), 2'b10 = CCW
//   out_src     [1:0]  input port the flit came from
//   drop_count  [7:0]  saturating count of discarded flits. This port exists
//               only when the ROUTER_DROP_CNT_EN macro is defined.
//
// Configuration macro
//   ROUTER_DROP_CNT_EN  adds the drop_count port and its counter. Routing is
//                       the same whether or not the macro is defined.
// -----------------------------------------------------------------------------
module ring_node_router #(
  parameter int NODE_ID    = 0,
  parameter int NUM_NODES  = 8,
  parameter int ID_W       = 3,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            in_valid,
  output logic [2:0]            in_ready,
  input  logic [3*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_dir,
  output logic [1:0]            out_src
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LP_DEPTH   = CW'(FIFO_DEPTH);

  // Routing arithmetic uses ID_W+1 bits so that dest+NUM_NODES cannot wrap.
  localparam logic [ID_W:0] LP_NODE = (ID_W+1)'(NODE_ID);
  localparam logic [ID_W:0] LP_NUM  = (ID_W+1)'(NUM_NODES);
  localparam logic [ID_W:0] LP_HALF = (ID_W+1)'(NUM_NODES / 2);

  localparam logic [1:0] DIR_CW    = 2'b00;
  localparam logic [1:0] DIR_LOCAL = 2'b01;
  localparam logic [1:0] DIR_CCW   = 2'b10;

  // Round-robin successor of a port index (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input FIFOs
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem   [3][FIFO_DEPTH];
  logic [AW-1:0]     r_wptr  [3];
  logic [AW-1:0]     r_rptr  [3];
  logic [CW-1:0]     r_count [3];

  // Cleared by reset and set on the first edge after it. This keeps in_ready
  // low throughout reset while still being derived from registers only.
  logic              r_rdy_en;

  logic [2:0]        w_push;
  logic [2:0]        w_pop;
  logic [2:0]        w_nonempty;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_ready[i]   = r_rdy_en && (r_count[i] != LP_DEPTH);
      w_nonempty[i] = (r_count[i] != '0);
    end
  end

  assign w_push = in_valid & in_ready;

  // Storage has no reset. Only the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy_en <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      r_rdy_en <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + LP_PTR_ONE;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + LP_PTR_ONE;
        // A simultaneous push and pop leaves the count unchanged.
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + LP_CNT_ONE;
          2'b01:   r_count[i] <= r_count[i] - LP_CNT_ONE;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [1:0] r_rr;
  logic [1:0] w_c0, w_c1, w_c2;
  logic [1:0] w_gnt;
  logic       w_gnt_vld;
  logic       w_free;
  logic       w_take;

  assign w_c0 = r_rr;
  assign w_c1 = f_next(r_rr);
  assign w_c2 = f_next(f_next(r_rr));

  // Grant goes to the first non-empty FIFO at or after r_rr.
  always_comb begin
    w_gnt     = 2'd0;
    w_gnt_vld = 1'b0;
    if (w_nonempty[w_c0]) begin
      w_gnt     = w_c0;
      w_gnt_vld = 1'b1;
    end else if (w_nonempty[w_c1]) begin
      w_gnt     = w_c1;
      w_gnt_vld = 1'b1;
    end else if (w_nonempty[w_c2]) begin
      w_gnt     = w_c2;
      w_gnt_vld = 1'b1;
    end
  end

  logic r_out_valid;

  // The output stage can be reloaded when it is empty or is being drained
  // on this edge.
  assign w_free = !r_out_valid || out_ready;
  assign w_take = w_free && w_gnt_vld;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_pop[i] = w_take && (w_gnt == 2'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Route computation on the granted head flit
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_head;
  logic [ID_W:0]     w_dest;
  logic [ID_W:0]     w_orig;
  logic [ID_W:0]     w_dist;
  logic              w_is_local;
  logic              w_bad_dest;
  logic              w_loop;
  logic              w_discard;
  logic [1:0]        w_dir;

  assign w_head = r_mem[w_gnt][r_rptr[w_gnt]];
  assign w_dest = {1'b0, w_head[DATA_W-1 -: ID_W]};
  assign w_orig = {1'b0, w_head[DATA_W-1-ID_W -: ID_W]};

  // Clockwise hop count from this node to dest, modulo the ring size.
  assign w_dist = (w_dest >= LP_NODE) ? (w_dest - LP_NODE)
                                      : (w_dest + LP_NUM - LP_NODE);

  assign w_is_local = (w_dest == LP_NODE);
  assign w_bad_dest = (w_dest >= LP_NUM);

  // A ring flit that has come back to its originator without being ejected
  // would circulate forever, so it is removed. Local injects are exempt.
  assign w_loop    = (w_gnt != 2'd1) && (w_orig == LP_NODE) && !w_is_local;
  assign w_discard = w_bad_dest || w_loop;

  // When the two paths are the same length, the flit goes CW.
  assign w_dir = w_is_local         ? DIR_LOCAL :
                 (w_dist <= LP_HALF) ? DIR_CW    : DIR_CCW;

  // ---------------------------------------------------------------------------
  // Output stage and arbiter pointer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_dir;
  logic [1:0]        r_out_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_dir   <= 2'b00;
      r_out_src   <= 2'b00;
      r_rr        <= 2'd0;
    end else if (w_free) begin
      // A discarded grant still consumes the slot and leaves the output empty.
      r_out_valid <= w_take && !w_discard;
      if (w_take) begin
        r_rr <= f_next(w_gnt);
        if (!w_discard) begin
          r_out_data <= w_head;
          r_out_dir  <= w_dir;
          r_out_src  <= w_gnt;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_dir   = r_out_dir;
  assign out_src   = r_out_src;

`ifdef ROUTER_DROP_CNT_EN
  // ---------------------------------------------------------------------------
  // Discard counter, saturating at 8'hFF
  // ---------------------------------------------------------------------------
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 8'h00;
    end else if (w_take && w_discard && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_ring_node_router.sv
// -----------------------------------------------------------------------------
// tb_ring_node_router
//   Bench for ring_node_router. It drives two instances:
//     A: NODE_ID=0, NUM_NODES=8 (every dest is valid)
//     B: NODE_ID=4, NUM_NODES=6 (dests 6 and 7 are invalid, and the clockwise
//        hop count wraps around the ring)
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ring_node_router;

  localparam int DW     = 32;
  localparam int ID_W   = 3;
  localparam int DEPTH  = 4;
  localparam int NODE_A = 0;
  localparam int NN_A   = 8;
  localparam int NODE_B = 4;
  localparam int NN_B   = 6;
  localparam int SB_W   = DW + 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Index 0 drives instance A and index 1 drives instance B.
  logic [2:0]        in_valid  [2];
  logic [2:0]        in_ready  [2];
  logic [3*DW-1:0]   in_data   [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic [DW-1:0]     out_data  [2];
  logic [1:0]        out_dir   [2];
  logic [1:0]        out_src   [2];
`ifdef ROUTER_DROP_CNT_EN
  logic [7:0]        drop_count [2];
`endif

  ring_node_router #(
    .NODE_ID(NODE_A), .NUM_NODES(NN_A), .ID_W(ID_W), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) u_dut_a (
    .clk(clk), .reset(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_dir(out_dir[0]), .out_src(out_src[0])
`ifdef ROUTER_DROP_CNT_EN
    , .drop_count(drop_count[0])
`endif
  );

  ring_node_router #(
    .NODE_ID(NODE_B), .NUM_NODES(NN_B), .ID_W(ID_W), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) u_dut_b (
    .clk(clk), .reset(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_dir(out_dir[1]), .out_src(out_src[1])
`ifdef ROUTER_DROP_CNT_EN
    , .drop_count(drop_count[1])
`endif
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int exp_drops [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_flit(input int dest, input int orig);
    logic [DW-2*ID_W-1:0] pay;
    logic [ID_W-1:0]      d;
    logic [ID_W-1:0]      o;
    pay = (DW-2*ID_W)'($urandom);
    d   = ID_W'(dest);
    o   = ID_W'(orig);
    return {d, o, pay};
  endfunction

  // Reference routing model. Returns {drop, dir}. It works from hop counts
  // on the ring, using plain integer arithmetic.
  function automatic logic [2:0] model_route(input int k, input int port, input logic [DW-1:0] f);
    int node, nn, dest, orig, cw_hops;
    node = (k == 0) ? NODE_A : NODE_B;
    nn   = (k == 0) ? NN_A   : NN_B;
    dest = int'(f[DW-1 -: ID_W]);
    orig = int'(f[DW-1-ID_W -: ID_W]);
    if (dest >= nn)                   return 3'b100;
    if (dest == node)                 return 3'b001;
    if (port != 1 && orig == node)    return 3'b100;
    cw_hops = (dest - node + nn) % nn;
    return (2 * cw_hops <= nn) ? 3'b000 : 3'b010;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 3'b000;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(negedge clk);
    exp_drops[0] = 0;
    exp_drops[1] = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard for the randomized phase: entries are {src, dir, data}
  // ---------------------------------------------------------------------------
  logic [SB_W-1:0] exp_q[$];

  task automatic sb_check_out(input int k);
    int idx;
    idx = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j][SB_W-1 -: 2] == out_src[k]) begin
        idx = j;
        break;
      end
    end
    if (idx < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected dut%0d: got src %0d data 0x%0h, expected no flit", k, out_src[k], out_data[k]);
    end else begin
      check($sformatf("sb_flit_dut%0d", k), {out_src[k], out_dir[k], out_data[k]}, exp_q[idx]);
      exp_q.delete(idx);
    end
  endtask

  task automatic run_random(input int k, input int cycles);
    logic [DW-1:0] f;
    logic [2:0]    r;
    int            node;
    node = (k == 0) ? NODE_A : NODE_B;
    exp_q.delete();
    for (int c = 0; c < cycles + 40; c++) begin
      out_ready[k] = (c >= cycles) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (out_valid[k] && out_ready[k]) sb_check_out(k);
      in_valid[k] = (c < cycles) ? 3'($urandom) : 3'b000;
      for (int p = 0; p < 3; p++) begin
        f = make_flit($urandom_range(0, 7),
                      ($urandom_range(0, 3) == 0) ? node : $urandom_range(0, 7));
        in_data[k][p*DW +: DW] = f;
        if (in_valid[k][p] && in_ready[k][p]) begin
          r = model_route(k, p, f);
          if (r[2]) exp_drops[k]++;
          else      exp_q.push_back({2'(p), r[1:0], f});
        end
      end
      @(negedge clk);
    end
    check($sformatf("sb_empty_dut%0d", k), 64'(exp_q.size()), 64'd0);
`ifdef ROUTER_DROP_CNT_EN
    check($sformatf("sb_drops_dut%0d", k), 64'(drop_count[k]), 64'(exp_drops[k]));
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Directed routing vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int         k;
    int         port;
    int         dest;
    int         orig;
    bit         drop;
    logic [1:0] dir;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic apply_vec(input int i);
    logic [DW-1:0] f;
    int k, p;
    k = vecs[i].k;
    p = vecs[i].port;
    f = make_flit(vecs[i].dest, vecs[i].orig);
    out_ready[k] = 1'b1;
    check($sformatf("vec%0d_in_ready", i), 64'(in_ready[k][p]), 64'd1);
    in_valid[k][p]         = 1'b1;
    in_data[k][p*DW +: DW] = f;
    @(negedge clk);                      // accepted at this edge (E)
    in_valid[k] = 3'b000;
    check($sformatf("vec%0d_lat_e", i), 64'(out_valid[k]), 64'd0);
    @(negedge clk);                      // E+1: granted
    if (vecs[i].drop) begin
      exp_drops[k]++;
      check($sformatf("vec%0d_dropped", i), 64'(out_valid[k]), 64'd0);
    end else begin
      check($sformatf("vec%0d_valid", i), 64'(out_valid[k]), 64'd1);
      check($sformatf("vec%0d_data", i),  64'(out_data[k]),  64'(f));
      check($sformatf("vec%0d_dir", i),   64'(out_dir[k]),   64'(vecs[i].dir));
      check($sformatf("vec%0d_src", i),   64'(out_src[k]),   64'(p));
    end
`ifdef ROUTER_DROP_CNT_EN
    check($sformatf("vec%0d_drop_count", i), 64'(drop_count[k]), 64'(exp_drops[k]));
`endif
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fl [10];
  logic [DW-1:0] pre [3][2];
  int            acc;
  bit            acc_now;
  int            seen;

  initial begin
    rst = 1'b1;
    idle_inputs();
    exp_drops[0] = 0;
    exp_drops[1] = 0;

    // Reset held for two edges, then released.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_out_valid_dut%0d", k), 64'(out_valid[k]), 64'd0);
      check($sformatf("rst_in_ready_dut%0d", k),  64'(in_ready[k]),  64'd0);
      check($sformatf("rst_out_fields_dut%0d", k),
            64'({out_data[k], out_dir[k], out_src[k]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("post_rst_in_ready_dut%0d", k), 64'(in_ready[k]),  64'd7);
      check($sformatf("post_rst_valid_dut%0d", k),    64'(out_valid[k]), 64'd0);
`ifdef ROUTER_DROP_CNT_EN
      check($sformatf("post_rst_drop_dut%0d", k), 64'(drop_count[k]), 64'd0);
`endif
    end

    // Routing table: {dut, port, dest, orig, drop, dir}
    vecs[0]  = '{0, 1, 3, 0, 1'b0, 2'b00};
    vecs[1]  = '{0, 1, 5, 0, 1'b0, 2'b10};
    vecs[2]  = '{0, 1, 4, 0, 1'b0, 2'b00};   // exactly half way goes CW
    vecs[3]  = '{0, 1, 0, 0, 1'b0, 2'b01};
    vecs[4]  = '{0, 0, 0, 0, 1'b0, 2'b01};   // ring flit ejecting at its origin
    vecs[5]  = '{0, 2, 2, 0, 1'b1, 2'b00};   // loop kill
    vecs[6]  = '{0, 0, 7, 3, 1'b0, 2'b10};
    vecs[7]  = '{0, 2, 1, 5, 1'b0, 2'b00};
    vecs[8]  = '{1, 1, 6, 4, 1'b1, 2'b00};   // dest beyond ring size
    vecs[9]  = '{1, 2, 2, 4, 1'b1, 2'b00};   // loop kill
    vecs[10] = '{1, 1, 1, 4, 1'b0, 2'b00};   // 3 hops of 6: tie goes CW
    vecs[11] = '{1, 0, 3, 1, 1'b0, 2'b10};
    vecs[12] = '{1, 2, 0, 2, 1'b0, 2'b00};
    vecs[13] = '{1, 0, 4, 4, 1'b0, 2'b01};
    vecs[14] = '{1, 1, 7, 0, 1'b1, 2'b00};
    for (int i = 0; i < NV; i++) apply_vec(i);

    // Back-pressure: port 0 fills while out_ready stays low.
    out_ready[0] = 1'b0;
    for (int i = 0; i < 10; i++) fl[i] = make_flit($urandom_range(1, 7), 2);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid[0][0]     = 1'b1;
      in_data[0][0 +: DW] = fl[(acc < 10) ? acc : 9];
      acc_now = in_ready[0][0];
      @(negedge clk);
      if (acc_now) acc++;
    end
    in_valid[0] = 3'b000;
    check("bp_accepts", 64'(acc), 64'(DEPTH + 1));
    check("bp_in_ready_low", 64'(in_ready[0][0]), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_valid", 64'(out_valid[0]), 64'd1);
      check("bp_hold_data", 64'(out_data[0]), 64'(fl[0]));
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    for (int j = 0; j < DEPTH + 1; j++) begin
      check($sformatf("bp_drain%0d_valid", j), 64'(out_valid[0]), 64'd1);
      check($sformatf("bp_drain%0d_data", j),  64'(out_data[0]),  64'(fl[j]));
      if (j == 1) check("bp_in_ready_back", 64'(in_ready[0][0]), 64'd1);
      @(negedge clk);
    end
    check("bp_drained", 64'(out_valid[0]), 64'd0);

    // Round robin: two flits preloaded in each FIFO, then drained.
    do_reset(1);
    out_ready[0] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      in_valid[0] = 3'b111;
      for (int p = 0; p < 3; p++) begin
        pre[p][n] = make_flit(1, 2);
        in_data[0][p*DW +: DW] = pre[p][n];
      end
      @(negedge clk);
    end
    in_valid[0]  = 3'b000;
    out_ready[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("rr%0d_valid", j), 64'(out_valid[0]), 64'd1);
      check($sformatf("rr%0d_src", j),   64'(out_src[0]),   64'(j % 3));
      check($sformatf("rr%0d_data", j),  64'(out_data[0]),  64'(pre[j % 3][j / 3]));
      @(negedge clk);
    end
    check("rr_done", 64'(out_valid[0]), 64'd0);

    // Reset while flits are held in the FIFO and in the output register.
    out_ready[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid[0][1]      = 1'b1;
      in_data[0][DW +: DW] = make_flit(2, 0);
      @(negedge clk);
    end
    in_valid[0] = 3'b000;
    check("mid_rst_pre_valid", 64'(out_valid[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
    rst = 1'b0;
    exp_drops[0] = 0;
    exp_drops[1] = 0;
    @(negedge clk);
    check("mid_rst_in_ready_back", 64'(in_ready[0]), 64'd7);
    out_ready[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid[0]) seen++;
      @(negedge clk);
    end
    check("mid_rst_no_stale", 64'(seen), 64'd0);

    // Randomized traffic against the scoreboard, on each instance in turn.
    run_random(0, 300);
    run_random(1, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
